// File: rtl/ps2_pkg.sv
// Shared constants, event layout and frame FSM states for the PS/2 receive path.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int         EV_W    = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin front end: synchronisers, clock deglitch filter, 11-bit frame FSM and stall timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       par_err,
  output logic       frm_err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic [7:0] flt_cnt_q, flt_cnt_d;
  logic       filt_q, filt_d;
  logic       filt_prev_q, filt_prev_d;
  logic       strobe_q, strobe_d;
  logic       bit_q, bit_d;

  ps2_state_t    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
  logic          stop_strobe;

  // The filtered clock only moves after FILTER consecutive disagreeing samples.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    flt_cnt_d   = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (flt_cnt_q == 8'(FILTER - 1)) filt_d = clk_sync_q[1];
      else                             flt_cnt_d = flt_cnt_q + 8'd1;
    end
    filt_prev_d = filt_q;
    strobe_d    = filt_prev_q & ~filt_q;
    bit_d       = data_sync_q[1];
  end

  // Pins idle high, so the front end resets to the idle level to avoid a false edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      flt_cnt_q   <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      strobe_q    <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      flt_cnt_q   <= flt_cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      strobe_q    <= strobe_d;
      bit_q       <= bit_d;
    end
  end

  assign tmo_hit = (state_q != ST_IDLE) && !strobe_q && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      if (state_q == ST_IDLE || strobe_q) tmo_q <= '0;
      else                                tmo_q <= tmo_q + 1'b1;
      if (tmo_hit) begin
        state_q <= ST_IDLE;
      end else if (strobe_q) begin
        case (state_q)
          ST_IDLE: begin
            if (!bit_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q   <= {bit_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= bit_q;
            state_q <= ST_STOP;
          end
          ST_STOP: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // A bad stop bit masks any parity verdict.
  assign stop_strobe = strobe_q && (state_q == ST_STOP);
  assign byte_valid  = stop_strobe && bit_q && (^{shift_q, par_q});
  assign par_err     = stop_strobe && bit_q && !(^{shift_q, par_q});
  assign frm_err     = (stop_strobe && !bit_q) || tmo_hit;
  assign byte_out    = shift_q;
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver top: E0/F0 prefix folding, full-capacity event FIFO and sticky status flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int AW      = 3,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000,
  parameter int DECODE  = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  input  logic            rdn,
  input  logic            err_clr,
  output logic [EV_W-1:0] data,
  output logic            ready,
  output logic [AW:0]     level,
  output logic            overflow,
  output logic            parity_err,
  output logic            frame_err
);
  localparam int DEPTH = 2 ** AW;

  logic       rx_valid, rx_par_err, rx_frm_err;
  logic [7:0] rx_byte;

  ps2_frame_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_frame_rx (
    .clk       (clk),
    .clr       (clr),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(rx_valid),
    .byte_out  (rx_byte),
    .par_err   (rx_par_err),
    .frm_err   (rx_frm_err)
  );

  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic          push, pop, full, wr_en;
  ps2_event_t    push_ev;
  ps2_event_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          parity_err_q, parity_err_d, frame_err_q, frame_err_d;

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push       = 1'b0;
    push_ev    = '{ext: ext_pend_q, brk: brk_pend_q, code: rx_byte};
    if (rx_par_err || rx_frm_err) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (rx_valid) begin
      if (DECODE != 0 && rx_byte == PS2_EXT)      ext_pend_d = 1'b1;
      else if (DECODE != 0 && rx_byte == PS2_BRK) brk_pend_d = 1'b1;
      else begin
        push       = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  always_comb begin
    pop      = !rdn && (level_q != '0);
    full     = (level_q == (AW + 1)'(DEPTH));
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !pop)      level_d = level_q + 1'b1;
    else if (!wr_en && pop) level_d = level_q - 1'b1;
    overflow_d   = (push && full && !pop) ? 1'b1 : (pop ? 1'b0 : overflow_q);
    parity_err_d = rx_par_err ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
    frame_err_d  = rx_frm_err ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_ev;
    end
  end

  assign data       = mem_q[rd_ptr_q];
  assign ready      = (level_q != '0);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device receiver for the keyboard/mouse input path, sitting between the PS/2 pins and the CPU I/O bus. It synchronises and deglitches the PS/2 clock, receives 11-bit frames through an explicit state machine with a stall timeout, and optionally folds E0/F0 scancode prefixes into single key events. Events are buffered in a full-capacity FIFO and read by the CPU, with sticky parity and framing error flags.

## Interface
- AW, 3: FIFO address width; depth = 2**AW entries, all usable.
- FILTER, 8: `clk` cycles the synchronised `ps2_clk` must be stable before the filtered clock changes (1..255).
- TIMEOUT, 100000: `clk` cycles without a sample strobe mid-frame before the frame is aborted (2 ms at 50 MHz).
- DECODE, 1: 1 = fold E0/F0 prefixes into events; 0 = raw byte per entry.
- clk  in  1  system clock, 50 MHz.
- clr  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock pin, asynchronous.
- ps2_data  in  1  PS/2 data pin, asynchronous.
- rdn  in  1  read strobe, active low; pops one entry per cycle while `ready`.
- err_clr  in  1  one-cycle pulse clearing `parity_err` and `frame_err`.
- data  out  10  head entry {ext, brk, code[7:0]}; valid while `ready`.
- ready  out  1  FIFO not empty.
- level  out  AW+1  current FIFO occupancy, 0..2**AW.
- overflow  out  1  sticky: an event was dropped on a full FIFO.
- parity_err  out  1  sticky: frame with even parity discarded.
- frame_err  out  1  sticky: bad stop bit or timeout.

## Operation
- `ps2_clk` and `ps2_data` each pass through 2 synchroniser flops. The filtered clock follows the synchronised clock only after FILTER equal consecutive samples. A 1→0 change of the filtered clock produces a one-cycle `strobe`. Data is sampled at the same pipeline depth as the clock.
- The frame FSM has states IDLE, DATA, PARITY and STOP. All transitions occur on `strobe`.
  - IDLE: data=0 → DATA with bit counter 0; data=1 → stay (stray edge ignored).
  - DATA: shift bits in LSB first; after bit 7 → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: always → IDLE. If data=1 and ^{byte,parity}=1, the byte is valid. Stop=0 sets `frame_err` (this check takes precedence). Bad parity sets `parity_err`. Invalid bytes are discarded.
- Timeout: in any state other than IDLE, a counter reloads on each `strobe`. Reaching TIMEOUT forces IDLE, sets `frame_err` and discards the partial byte.
- Decoder, DECODE=1:
  - Byte E0 sets `ext_pend`; byte F0 sets `brk_pend`; neither is pushed.
  - Any other byte pushes {ext_pend, brk_pend, byte}, then clears both pending flags.
  - A frame error, parity error or timeout also clears both pending flags.
- Decoder, DECODE=0: every valid byte is pushed as {0, 0, byte}.
- FIFO: pointers of AW bits plus an (AW+1)-bit `level`; full when `level` = 2**AW.
  - A push while full, with no pop in the same cycle, drops the event and sets `overflow`.
  - Simultaneous push and pop while full: both succeed, `level` is unchanged, no overflow.
  - Pop (`rdn`=0 and `ready`) advances the read pointer and clears `overflow`.
  - `rdn`=0 while empty is ignored.
  - Pointers wrap modulo 2**AW.
- Error flags: if set and `err_clr` coincide in the same cycle, the set wins.

## Timing
- All outputs reset to 0: `data`=0 (storage is reset), `ready`=0, `level`=0, all flags 0. The FSM resets to IDLE; pending flags and the filter and timeout counters reset to 0.
- A `clr` asserted mid-frame aborts the frame immediately; no error flag is set.
- Pin-to-`strobe` latency: 2 + FILTER + 1 cycles after the pin falls.
- The event is written at the `clk` edge following the STOP `strobe`. `ready` and `level` update in that same cycle, one cycle after the strobe.
- `data` is combinational from the head entry. After a pop, the next entry appears the cycle after the popping edge.
- Error flags set one cycle after the STOP `strobe` or the timeout expiry.

## Structure
- Package `ps2_pkg` holds:
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the event width (10) and the event struct {ext, brk, code};
  - the FSM state enum.
- Sub-module `ps2_frame_rx` contains the synchronisers, filter, FSM and timeout. Its outputs are `byte_valid`, `byte`, `par_err` and `frm_err`, each a one-cycle pulse.
- The top level holds the decoder, FIFO and flags.

## Test plan
- Frame 0x1C (parity 0, stop 1) with DECODE=1 → one entry, `data`=10'h01C, `level`=1. One pop → `ready`=0.
- Bytes E0, F0, 75 → single entry 10'h375, `level`=1. With DECODE=0, the same stimulus gives three entries: 0E0, 0F0, 075.
- 9 frames with AW=3 and no reads → `level`=8, `overflow`=1, entries 1-8 intact. One pop → `overflow`=0, `level`=7.
- Frame 0x1C with the parity bit flipped → no push, `parity_err`=1. Stop bit 0 → `frame_err`=1. Pulsing `err_clr` clears both.
- Stop `ps2_clk` after 4 data bits with TIMEOUT=2000 → `frame_err`=1 at cycle 2000 after the last strobe. A following clean frame 0x1C is received correctly.
- 3-cycle glitch low on `ps2_clk` with FILTER=8 → no strobe, FSM stays in IDLE. Full FIFO with a push and a pop in the same cycle → `level` stays 8, `overflow`=0.
